// File: rtl/hilo_mult_unit_pkg.sv
// HI/LO command codes and FSM encodings shared by decode and EX.
// Also provides helpers that classify an ALUOp.
package hilo_mult_unit_pkg;

    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b11000;
    localparam logic [4:0] OP_MADD  = 5'b01111;
    localparam logic [4:0] OP_MSUB  = 5'b01110;
    localparam logic [4:0] OP_MTHI  = 5'b10010;
    localparam logic [4:0] OP_MTLO  = 5'b10011;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        K_MUL,
        K_MADD,
        K_MSUB
    } kind_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_hilo(input logic [4:0] op);
        return is_mul(op) ||
               (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
    endfunction

endpackage

// File: rtl/hilo_mult_unit_if.sv
// Decode-to-EX HI/LO command bus and its result/status return.
interface hilo_mult_unit_if;
    logic        Start;
    logic        Flush;
    logic [4:0]  ALUOp;
    logic        Hi_write;
    logic        Lo_write;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic        Done;

    modport master (
        output Start, Flush, ALUOp, Hi_write, Lo_write, A, B,
        input  Hi, Lo, Busy, Stall, Done
    );

    modport slave (
        input  Start, Flush, ALUOp, Hi_write, Lo_write, A, B,
        output Hi, Lo, Busy, Stall, Done
    );
endinterface

// File: rtl/hilo_mult_core.sv
// Iterative shift-add unsigned 32x32 multiplier.
// Retires BITS_PER_CYCLE multiplier bits per step, LSB first.
module hilo_mult_core #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic [63:0] prod,
    output logic        last
);
    localparam int NUM_ITER = 32 / BITS_PER_CYCLE;
    localparam int CW = 6;

    logic [63:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [63:0]   prod_q, prod_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {32'b0, mcand};
            mplier_d = mplier;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                if (mplier_q[i]) prod_d = prod_d + (mcand_q << i);
            end
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod = prod_q;
    assign last = (cnt_q == CW'(NUM_ITER - 1));
endmodule

// File: rtl/hilo_mult_unit.sv
// EX-stage HI/LO unit: owns HI/LO, sequences multiplies, stalls decode.
// Signed ops multiply magnitudes and fix the sign in FINISH.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    hilo_mult_unit_if.slave  bus
);
    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        load, step, last;
    logic        mul_ok, signed_op;
    logic [31:0] mag_a, mag_b;
    logic [63:0] prod, p, acc;

    hilo_mult_core #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
        .clk    (Clk),
        .rst    (Reset),
        .load   (load),
        .step   (step),
        .mcand  (mag_a),
        .mplier (mag_b),
        .prod   (prod),
        .last   (last)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        sign_d    = sign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        load      = 1'b0;
        step      = 1'b0;
        mul_ok    = bus.Start & bus.Hi_write & bus.Lo_write &
                    is_mul(bus.ALUOp);
        signed_op = (bus.ALUOp != OP_MULTU);
        mag_a     = (signed_op & bus.A[31]) ? -bus.A : bus.A;
        mag_b     = (signed_op & bus.B[31]) ? -bus.B : bus.B;
        acc       = {hi_q, lo_q};
        p         = sign_q ? -prod : prod;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.Flush && bus.Start) begin
                    if (mul_ok) begin
                        load    = 1'b1;
                        sign_d  = signed_op & (bus.A[31] ^ bus.B[31]);
                        state_d = S_ITER;
                        unique case (1'b1)
                            (bus.ALUOp == OP_MADD): kind_d = K_MADD;
                            (bus.ALUOp == OP_MSUB): kind_d = K_MSUB;
                            default:                kind_d = K_MUL;
                        endcase
                    end else if (bus.ALUOp == OP_MTHI &&
                                 bus.Hi_write && !bus.Lo_write) begin
                        hi_d = bus.A;
                    end else if (bus.ALUOp == OP_MTLO &&
                                 bus.Lo_write && !bus.Hi_write) begin
                        lo_d = bus.A;
                    end
                end
            end
            S_ITER: begin
                step = 1'b1;
                if (bus.Flush)  state_d = S_IDLE;
                else if (last)  state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                // A flush landing on the write edge still wins
                if (!bus.Flush) begin
                    unique case (kind_q)
                        K_MADD:  {hi_d, lo_d} = acc + p;
                        K_MSUB:  {hi_d, lo_d} = acc - p;
                        default: {hi_d, lo_d} = p;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_MUL;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.Hi    = hi_q;
    assign bus.Lo    = lo_q;
    assign bus.Busy  = (state_q != S_IDLE);
    assign bus.Stall = bus.Start & bus.Busy & is_hilo(bus.ALUOp);
    assign bus.Done  = (state_q == S_FINISH) & ~bus.Flush;
endmodule
